// File: rtl/uc_pkg.sv
// ---------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the accumulator-machine control unit:
//   - instruction class codes (bits [15:14] of the instruction word)
//   - bit positions of the instruction fields
//   - the sequencer state encoding
//   - a small helper that extracts the class field from an instruction word
// ---------------------------------------------------------------------------
package uc_pkg;

  localparam int unsigned INSTR_W = 16;

  // Instruction field positions
  localparam int unsigned IR_CLASS_HI = 15;
  localparam int unsigned IR_CLASS_LO = 14;
  localparam int unsigned IR_SEL_HI   = 13;
  localparam int unsigned IR_SEL_LO   = 11;
  localparam int unsigned IR_ADDR_MAX = 11;

  // Instruction classes
  localparam logic [1:0] CL_ALU = 2'b00;
  localparam logic [1:0] CL_STA = 2'b01;
  localparam logic [1:0] CL_JCC = 2'b10;
  localparam logic [1:0] CL_JMP = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_LOAD   = 3'd4,
    ST_ALU    = 3'd5
  } uc_state_e;

  function automatic logic [1:0] instr_class(input logic [INSTR_W-1:0] word);
    return word[IR_CLASS_HI:IR_CLASS_LO];
  endfunction

endpackage

// File: rtl/uc_sequencer_pc.sv
// ---------------------------------------------------------------------------
// uc_pc
// Program counter of the control unit.
//   clk, rst  : clock and asynchronous active-high reset (loads RESET_PC)
//   ce        : clock enable; when low the counter holds
//   inc       : advance by one, wrapping modulo 2^ADDR_W
//   load      : load load_val (jump); has priority over inc
//   load_val  : jump target
//   pc        : current program counter
// ---------------------------------------------------------------------------
module uc_pc #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // The natural ADDR_W-bit overflow of the increment provides the wrap
  // from the last address back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (ce) begin
      if (load) begin
        pc <= load_val;
      end else if (inc) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/uc_sequencer.sv
// ---------------------------------------------------------------------------
// uc_sequencer
// Control unit of the accumulator processor. Fetches 16-bit instructions
// from a synchronous single-port memory (1-cycle read latency), decodes
// them and drives the datapath strobes.
//   clk, rst    : clock, asynchronous active-high reset
//   ce          : clock enable; 0 freezes state/pc/ir and zeroes all strobes
//   mem_rdata   : memory read data (valid the cycle after a read request)
//   carry       : datapath carry flag, tested by JCC
//   mem_addr    : memory address (0 when no access is made)
//   mem_en      : memory access request
//   mem_we      : memory write strobe (write data is the accumulator)
//   sel_UAL     : ALU operation select, always ir[13:11]
//   load_R1     : R1 loads mem_rdata
//   load_accu   : accumulator loads the ALU result
//   load_carry  : carry register loads the ALU carry
//   init_carry  : carry register clears
// ---------------------------------------------------------------------------
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [15:0]       mem_rdata,
  input  logic              carry,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              init_carry
);

  uc_state_e         state;
  uc_state_e         state_next;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ir_addr;
  logic [1:0]        ir_class;
  logic              pc_inc;
  logic              pc_load;
  logic              active;

  logic [ADDR_W-1:0] addr_c;
  logic              en_c;
  logic              we_c;
  logic              r1_c;
  logic              accu_c;
  logic              lcarry_c;
  logic              icarry_c;

  assign ir_addr  = ir[ADDR_W-1:0];
  assign ir_class = instr_class(ir);

  // Bits between the address field and the ALU select carry no meaning.
  generate
    if (ADDR_W < IR_ADDR_MAX) begin : g_unused_ir
      logic unused_ir_bits;
      assign unused_ir_bits = ^ir[IR_ADDR_MAX-1:ADDR_W];
    end
  endgenerate

  // Strobes are only allowed out while enabled and out of reset.
  assign active = ce & ~rst;

  // The PC advances once per instruction in DECODE and is overwritten in
  // EXEC by a taken jump; both are qualified by ce inside uc_pc.
  assign pc_inc  = (state == ST_DECODE);
  assign pc_load = (state == ST_EXEC) &&
                   ((ir_class == CL_JMP) || ((ir_class == CL_JCC) && !carry));

  uc_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (ir_addr),
    .pc       (pc)
  );

  // State register; a disabled cycle leaves the sequencer where it was so
  // that no step is lost when ce returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // The instruction register captures the word requested in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (ce && (state == ST_DECODE)) begin
      ir <= mem_rdata;
    end
  end

  // Next-state and raw (ungated) Moore decode of the control strobes.
  always_comb begin
    state_next = state;
    addr_c     = '0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    r1_c       = 1'b0;
    accu_c     = 1'b0;
    lcarry_c   = 1'b0;
    icarry_c   = 1'b0;
    case (state)
      ST_INIT: begin
        icarry_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        addr_c     = pc;
        en_c       = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        case (ir_class)
          CL_ALU: begin
            addr_c     = ir_addr;
            en_c       = 1'b1;
            state_next = ST_LOAD;
          end
          CL_STA: begin
            addr_c = ir_addr;
            en_c   = 1'b1;
            we_c   = 1'b1;
          end
          CL_JCC: begin
            icarry_c = carry;
          end
          default: begin
          end
        endcase
      end
      ST_LOAD: begin
        r1_c       = 1'b1;
        state_next = ST_ALU;
      end
      ST_ALU: begin
        accu_c     = 1'b1;
        lcarry_c   = 1'b1;
        state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign mem_addr   = rst ? '0 : addr_c;
  assign mem_en     = en_c & active;
  assign mem_we     = we_c & active;
  assign load_R1    = r1_c & active;
  assign load_accu  = accu_c & active;
  assign load_carry = lcarry_c & active;
  assign init_carry = icarry_c & active;
  assign sel_UAL    = ir[IR_SEL_HI:IR_SEL_LO];

endmodule

// File: tb/tb_uc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uc_sequencer
// Bench for uc_sequencer (ADDR_W=6, RESET_PC=0) with a behavioural
// synchronous memory. A per-cycle table of {rst, ce, carry, expected
// outputs} drives the program through ALU, STA, JCC (both outcomes) and JMP,
// a clock-enable freeze in LOAD and a reset pulse inside a STA; a second
// table covers the jump to the last address and the sequential wrap to 0.
// ---------------------------------------------------------------------------
module tb_uc_sequencer;

  localparam int ADDR_W = 6;
  localparam logic [15:0] ACCU_VAL = 16'hA5A5;

  typedef struct {
    logic       rst;
    logic       ce;
    logic       carry;
    logic [5:0] addr;
    logic       en;
    logic       we;
    logic [2:0] sel;
    logic       r1;
    logic       accu;
    logic       lc;
    logic       ic;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce = 1'b1;
  logic [15:0]       mem_rdata = '0;
  logic              carry = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [2:0]        sel_UAL;
  logic              load_R1;
  logic              load_accu;
  logic              load_carry;
  logic              init_carry;

  logic [15:0] mem [64];
  int          write_count = 0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [14:0] exp_q [$];
  string       tag_q [$];
  vec_t        vecs  [$];

  uc_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .mem_rdata  (mem_rdata),
    .carry      (carry),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .sel_UAL    (sel_UAL),
    .load_R1    (load_R1),
    .load_accu  (load_accu),
    .load_carry (load_carry),
    .init_carry (init_carry)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory; write data stands in for the accumulator.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= ACCU_VAL;
        write_count   <= write_count + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t v(input logic r, input logic c, input logic cy,
                             input logic [5:0] a, input logic en, input logic we,
                             input logic [2:0] s, input logic r1, input logic ac,
                             input logic lc, input logic ic);
    vec_t t;
    t.rst = r; t.ce = c; t.carry = cy; t.addr = a; t.en = en; t.we = we;
    t.sel = s; t.r1 = r1; t.accu = ac; t.lc = lc; t.ic = ic;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Drive one cycle's inputs at the falling edge and queue what must appear.
  task automatic applyStimulus(input vec_t t, input string name);
    @(negedge clk);
    rst   = t.rst;
    ce    = t.ce;
    carry = t.carry;
    exp_q.push_back({t.addr, t.en, t.we, t.sel, t.r1, t.accu, t.lc, t.ic});
    tag_q.push_back(name);
  endtask

  // Compare the settled outputs well before the next rising edge.
  task automatic checkOutput();
    logic [14:0] e;
    logic [14:0] a;
    string       n;
    #1;
    e = exp_q.pop_front();
    n = tag_q.pop_front();
    a = {mem_addr, mem_en, mem_we, sel_UAL, load_R1, load_accu, load_carry, init_carry};
    check(n, 32'(a), 32'(e));
  endtask

  task automatic run_table(input string phase);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("%s[%0d]", phase, i));
      checkOutput();
    end
    vecs.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0805;
    mem[1]  = 16'h4006;
    mem[2]  = 16'h8003;
    mem[3]  = 16'h8004;
    mem[4]  = 16'hC03F;
    mem[63] = 16'hC000;

    //              rst ce cy addr en we sel r1 ac lc ic
    vecs.push_back(v(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1)); // INIT
    vecs.push_back(v(0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0)); // FETCH 0
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  5, 1, 0, 1, 0, 0, 0, 0)); // EXEC ALU
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0)); // LOAD
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 1, 0, 1, 1, 0)); // ALU
    vecs.push_back(v(0, 1, 0,  1, 1, 0, 1, 0, 0, 0, 0)); // FETCH 1
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  6, 1, 1, 0, 0, 0, 0, 0)); // EXEC STA
    vecs.push_back(v(0, 1, 0,  2, 1, 0, 0, 0, 0, 0, 0)); // FETCH 2
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // EXEC JCC taken
    vecs.push_back(v(0, 1, 0,  3, 1, 0, 0, 0, 0, 0, 0)); // FETCH 3
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1)); // EXEC JCC not taken
    vecs.push_back(v(0, 1, 0,  4, 1, 0, 0, 0, 0, 0, 0)); // FETCH 4
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // EXEC JMP 63
    vecs.push_back(v(0, 1, 0, 63, 1, 0, 0, 0, 0, 0, 0)); // FETCH 63
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // EXEC JMP 0
    vecs.push_back(v(0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0)); // FETCH 0
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  5, 1, 0, 1, 0, 0, 0, 0)); // EXEC ALU
    vecs.push_back(v(0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); // LOAD frozen x4
    vecs.push_back(v(0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0)); // LOAD resumes
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 1, 0, 1, 1, 0)); // ALU
    vecs.push_back(v(0, 1, 0,  1, 1, 0, 1, 0, 0, 0, 0)); // FETCH 1
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // EXEC STA aborted
    vecs.push_back(v(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    run_table("main");

    // Restart from reset with a jump to the last address and a STA there,
    // after which the sequential fetch must wrap to address 0.
    mem[0]  = 16'hC03F;
    mem[63] = 16'h4010;
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1)); // INIT
    vecs.push_back(v(0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0)); // FETCH 0
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // EXEC JMP 63
    vecs.push_back(v(0, 1, 0, 63, 1, 0, 0, 0, 0, 0, 0)); // FETCH 63
    vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // DECODE
    vecs.push_back(v(0, 1, 0, 16, 1, 1, 0, 0, 0, 0, 0)); // EXEC STA 16
    vecs.push_back(v(0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0)); // FETCH 0 (wrap)
    run_table("wrap");

    @(negedge clk);
    check("write_count", 32'(write_count), 32'd2);
    check("mem6", 32'(mem[6]), 32'(ACCU_VAL));
    check("mem16", 32'(mem[16]), 32'(ACCU_VAL));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
# uc_sequencer

Control unit for the accumulator datapath (R1 register, 3-bit-select ALU, carry register, accumulator). It fetches 16-bit instruction words from a synchronous single-port memory and decodes them. It drives the datapath strobes (`load_R1`, `load_accu`, `load_carry`, `init_carry`, `sel_UAL`) and the memory address and write-enable. Together with the datapath it forms the processor core; the memory write data is the accumulator output, wired outside this block.

## Interface
- `ADDR_W`, default 6: memory address width and PC width; legal range 1..11.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ce` in 1: clock enable; 0 freezes the block.
- `mem_rdata` in 16: memory read data, valid one cycle after a read request.
- `carry` in 1: carry flag from the datapath.
- `mem_addr` out ADDR_W: memory address.
- `mem_en` out 1: memory access request (read or write).
- `mem_we` out 1: memory write strobe; write data is the accumulator.
- `sel_UAL` out 3: ALU operation select.
- `load_R1` out 1: R1 loads `mem_rdata`.
- `load_accu` out 1: accumulator loads the ALU result.
- `load_carry` out 1: carry register loads the ALU carry.
- `init_carry` out 1: carry register clears.

## Operation
- Instruction word format:
  - [15:14] class: 00 ALU, 01 STA, 10 JCC, 11 JMP.
  - [13:11] ALU select.
  - [ADDR_W-1:0] address; bits [10:ADDR_W] ignored.
- Registers: `pc` (ADDR_W bits), `ir` (16 bits), `state`.
- FSM states and actions:
  - INIT: `init_carry`=1 → FETCH.
  - FETCH: `mem_addr`=`pc`, `mem_en`=1 → DECODE.
  - DECODE: `ir` ← `mem_rdata`; `pc` ← `pc`+1 (mod 2^ADDR_W) → EXEC.
  - EXEC, class ALU: `mem_addr`=`ir`.addr, `mem_en`=1 → LOAD.
  - EXEC, class STA: `mem_addr`=`ir`.addr, `mem_en`=1, `mem_we`=1 → FETCH.
  - EXEC, class JCC: if `carry`=0, `pc` ← `ir`.addr; else `init_carry`=1 and `pc` unchanged → FETCH.
  - EXEC, class JMP: `pc` ← `ir`.addr → FETCH.
  - LOAD: `load_R1`=1 → ALU.
  - ALU: `load_accu`=1, `load_carry`=1 → FETCH.
- `sel_UAL` = `ir`[13:11] in every state; stable from EXEC through ALU.
- `mem_addr` = 0 in states that make no memory access.
- `ce`=0:
  - `state`, `pc` and `ir` hold.
  - All strobes (`mem_en`, `mem_we`, `load_*`, `init_carry`) are forced to 0.
  - On `ce` returning to 1, execution resumes in the frozen state with no step lost.
- `pc` wrap: the increment from 2^ADDR_W−1 gives 0.
- A jump target equal to the current `pc` is legal and loops forever.

## Timing
- Strobes are Moore outputs: a combinational decode of `state`/`ir`, ANDed with `ce` and !`rst`.
- Reset values (while `rst`=1):
  - `state`=INIT, `pc`=`RESET_PC`, `ir`=0.
  - All strobes 0, `mem_addr`=0, `sel_UAL`=0.
- Reset asserted mid-instruction aborts it immediately.
  - A STA aborted in EXEC produces no write.
  - After release, execution restarts at INIT.
- Memory read latency: 1 cycle. Data for a read issued in cycle N is sampled in cycle N+1.
- Instruction latency in enabled cycles, FETCH to next FETCH:
  - ALU: 5.
  - STA, JCC, JMP: 3.
- First FETCH is 1 cycle after reset release (INIT lasts one enabled cycle).
- The JCC `carry` test samples the datapath carry in EXEC. That value reflects the preceding ALU instruction.

## Structure
- Shared package `uc_pkg` holds:
  - Class constants `CL_ALU`, `CL_STA`, `CL_JCC`, `CL_JMP`.
  - The state enum (INIT, FETCH, DECODE, EXEC, LOAD, ALU).
  - Instruction field bit positions.
- One natural sub-module: `uc_pc`, the program counter with reset value, increment, load and `ce` hold.
- Everything else stays in `uc_sequencer`.
- Top-level integration pairs this block with the datapath. Memory write data = datapath `data_out`; memory read data feeds both `mem_rdata` and datapath `data_in`.

## Test plan
- Reset release, `ce`=1:
  - Cycle 0: `init_carry`=1.
  - Cycle 1: `mem_addr`=0, `mem_en`=1.
  - Cycle 3: `pc`=1.
- ALU instruction 0x0805 at address 0:
  - EXEC cycle: `mem_addr`=5, `mem_en`=1.
  - Next cycle: `load_R1`=1.
  - Next cycle: `load_accu`=`load_carry`=1 with `sel_UAL`=3'b001.
  - Then FETCH at address 1.
- STA 0x4006: EXEC cycle has `mem_addr`=6, `mem_we`=1, `mem_en`=1 for exactly one cycle; FETCH follows immediately.
- JCC 0x8003:
  - `carry`=0: next FETCH `mem_addr`=3.
  - `carry`=1: `init_carry`=1 in EXEC and next FETCH at `pc`+1.
- JMP 0xC000 at address 63 (`ADDR_W`=6): jumps to 0. Sequential fetch past 63 also wraps to 0.
- Robustness:
  - `ce`=0 for 4 cycles in LOAD: all strobes 0 and state held; `load_R1` appears on the first enabled cycle.
  - `rst` pulse during EXEC of STA: no `mem_we`; restart at `RESET_PC`.
